// File: rtl/data_types.sv
// Shared types for the branch checkpoint / flush control slice.
// Holds word, checkpoint and flush-state definitions.
package data_types;

  typedef logic [31:0] word32_t;

  typedef struct packed {
    logic    taken;
    word32_t alt_pc;
  } br_ckpt_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

endpackage

// File: rtl/br_ckpt_fifo.sv
// In-order checkpoint FIFO for predicted branches.
// Push/pop/clear with full/empty/count status; head is combinational.
module br_ckpt_fifo
  import data_types::*;
#(
  parameter int PW = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        clear_i,
  input  br_ckpt_t    wdata_i,
  output br_ckpt_t    head_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [PW:0] count_o
);

  localparam int DEPTH = 1 << PW;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  br_ckpt_t      r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;

  logic w_do_pop;
  logic w_do_push;

  assign full_o  = (r_count == FULL_CNT);
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rptr];

  // A full FIFO still accepts a push when the head leaves this cycle.
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  // Pointer, count and storage update; clear wins over push/pop.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (clear_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= wdata_i;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/branch_flush_ctrl.sv
// Sequences fetch, predictor and IQ around in-flight predicted branches.
// Checkpoints branches, retires on resolve, flushes/redirects on mispredict.
module branch_flush_ctrl
  import data_types::*;
#(
  parameter int MAX_BR_POW2 = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 issuing_branch_i,
  input  logic                 br_taken_i,
  input  word32_t              alt_pc_i,
  input  logic                 cond_eval_i,
  input  logic                 corr_pred_i,
  output logic                 fetch_stall_o,
  output logic                 iq_flush_o,
  output logic                 redirect_valid_o,
  output word32_t              redirect_pc_o,
  output logic                 bp_update_o,
  output logic                 bp_actual_taken_o,
  output logic [MAX_BR_POW2:0] outstanding_o,
  output logic                 proto_err_o
);

  flush_state_e r_state;
  flush_state_e w_state_nxt;

  br_ckpt_t             w_wdata;
  br_ckpt_t             w_head;
  logic                 w_full;
  logic                 w_empty;
  logic [MAX_BR_POW2:0] w_count;

  logic w_run;
  logic w_resolve;
  logic w_correct;
  logic w_mispred;
  logic w_push;
  logic w_push_err;
  logic w_eval_err;

  logic    r_bp_update;
  logic    r_bp_taken;
  word32_t r_redirect_pc;
  logic    r_proto_err;

  assign w_run     = (r_state == RUN);
  assign w_resolve = w_run && cond_eval_i && !w_empty;
  assign w_correct = w_resolve && corr_pred_i;
  assign w_mispred = w_resolve && !corr_pred_i;

  // A branch issued alongside a mispredict is wrong-path: drop it quietly.
  assign w_push     = w_run && issuing_branch_i && !w_mispred;
  assign w_push_err = w_push && w_full && !w_correct;
  assign w_eval_err = w_run && cond_eval_i && w_empty;

  assign w_wdata.taken  = br_taken_i;
  assign w_wdata.alt_pc = alt_pc_i;

  br_ckpt_fifo #(
    .PW (MAX_BR_POW2)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (w_push),
    .pop_i   (w_correct),
    .clear_i (w_mispred),
    .wdata_i (w_wdata),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // Flush state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a mispredict spends exactly one cycle in FLUSH.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN: begin
        if (w_mispred) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // Predictor feedback and recovery PC, registered off the resolve.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_bp_update   <= 1'b0;
      r_bp_taken    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_bp_update <= w_resolve;
      if (w_correct) begin
        r_bp_taken <= w_head.taken;
      end else if (w_mispred) begin
        r_bp_taken    <= ~w_head.taken;
        r_redirect_pc <= w_head.alt_pc;
      end
    end
  end

  // Sticky protocol error: overflow push or resolve with nothing live.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_proto_err <= 1'b0;
    end else if (w_push_err || w_eval_err) begin
      r_proto_err <= 1'b1;
    end
  end

  assign fetch_stall_o     = w_full || (r_state == FLUSH);
  assign iq_flush_o        = (r_state == FLUSH);
  assign redirect_valid_o  = (r_state == FLUSH);
  assign redirect_pc_o     = r_redirect_pc;
  assign bp_update_o       = r_bp_update;
  assign bp_actual_taken_o = r_bp_taken;
  assign outstanding_o     = w_count;
  assign proto_err_o       = r_proto_err;

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Directed plus randomized bench for branch_flush_ctrl.
// Reference model keeps checkpoints in a queue and applies the rules.
module tb_branch_flush_ctrl;

  localparam int PW    = 1;
  localparam int DEPTH = 1 << PW;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          issuing_branch_i;
  logic          br_taken_i;
  logic [31:0]   alt_pc_i;
  logic          cond_eval_i;
  logic          corr_pred_i;
  logic          fetch_stall_o;
  logic          iq_flush_o;
  logic          redirect_valid_o;
  logic [31:0]   redirect_pc_o;
  logic          bp_update_o;
  logic          bp_actual_taken_o;
  logic [PW:0]   outstanding_o;
  logic          proto_err_o;

  branch_flush_ctrl #(
    .MAX_BR_POW2 (PW)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .issuing_branch_i  (issuing_branch_i),
    .br_taken_i        (br_taken_i),
    .alt_pc_i          (alt_pc_i),
    .cond_eval_i       (cond_eval_i),
    .corr_pred_i       (corr_pred_i),
    .fetch_stall_o     (fetch_stall_o),
    .iq_flush_o        (iq_flush_o),
    .redirect_valid_o  (redirect_valid_o),
    .redirect_pc_o     (redirect_pc_o),
    .bp_update_o       (bp_update_o),
    .bp_actual_taken_o (bp_actual_taken_o),
    .outstanding_o     (outstanding_o),
    .proto_err_o       (proto_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          tk;
    logic [31:0] pc;
  } ck_t;

  ck_t         q[$];
  bit          m_flush;
  bit          m_err;
  bit          m_bpu;
  bit          m_bpt;
  logic [31:0] m_pc;

  int ncmp  = 0;
  int nfail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_flush = 0;
    m_err   = 0;
    m_bpu   = 0;
    m_bpt   = 0;
    m_pc    = '0;
  endtask

  task automatic check_all(input string tag);
    bit stall;
    stall = (q.size() == DEPTH) || m_flush;
    chk({tag, ".stall"}, 32'(fetch_stall_o), 32'(stall));
    chk({tag, ".flush"}, 32'(iq_flush_o), 32'(m_flush));
    chk({tag, ".rdv"}, 32'(redirect_valid_o), 32'(m_flush));
    chk({tag, ".rpc"}, redirect_pc_o, m_pc);
    chk({tag, ".bpu"}, 32'(bp_update_o), 32'(m_bpu));
    chk({tag, ".bpt"}, 32'(bp_actual_taken_o), 32'(m_bpt));
    chk({tag, ".out"}, 32'(outstanding_o), 32'(q.size()));
    chk({tag, ".err"}, 32'(proto_err_o), 32'(m_err));
  endtask

  // Apply one cycle of inputs, advance the model, check after the edge.
  task automatic step(input string tag, input bit iss, input bit tk,
                      input logic [31:0] pc, input bit ev, input bit cp);
    ck_t e;
    bit  nflush;
    bit  nbpu;
    issuing_branch_i = iss;
    br_taken_i       = tk;
    alt_pc_i         = pc;
    cond_eval_i      = ev;
    corr_pred_i      = cp;
    #1;
    chk({tag, ".pre_stall"}, 32'(fetch_stall_o),
        32'((q.size() == DEPTH) || m_flush));
    nflush = 0;
    nbpu   = 0;
    if (!m_flush) begin
      if (ev && q.size() == 0) m_err = 1;
      if (ev && q.size() > 0 && cp) begin
        e = q.pop_front();
        nbpu  = 1;
        m_bpt = e.tk;
        if (iss) q.push_back('{tk, pc});
      end else if (ev && q.size() > 0) begin
        e = q[0];
        nbpu   = 1;
        nflush = 1;
        m_bpt  = !e.tk;
        m_pc   = e.pc;
        q.delete();
      end else if (iss) begin
        if (q.size() < DEPTH) q.push_back('{tk, pc});
        else m_err = 1;
      end
    end
    m_flush = nflush;
    m_bpu   = nbpu;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i          = 1'b1;
    issuing_branch_i = 0;
    br_taken_i       = 0;
    alt_pc_i         = '0;
    cond_eval_i      = 0;
    corr_pred_i      = 0;
    do_reset();

    // 1: issue then correct resolve
    step("t1_iss", 1, 0, 32, 0, 0);
    chk("t1_out1", 32'(outstanding_o), 1);
    step("t1_res", 0, 0, 0, 1, 1);
    chk("t1_bpu", 32'(bp_update_o), 1);
    chk("t1_bpt", 32'(bp_actual_taken_o), 0);
    chk("t1_out0", 32'(outstanding_o), 0);

    // 2: issue then mispredict
    step("t2_iss", 1, 1, 40, 0, 0);
    step("t2_mis", 0, 0, 0, 1, 0);
    chk("t2_flush", 32'(iq_flush_o), 1);
    chk("t2_rpc", redirect_pc_o, 40);
    chk("t2_bpt", 32'(bp_actual_taken_o), 0);
    step("t2_post", 0, 0, 0, 0, 0);
    chk("t2_stall_off", 32'(fetch_stall_o), 0);
    chk("t2_rpc_hold", redirect_pc_o, 40);

    // 3: fill, overflow, drain one
    step("t3_a", 1, 0, 8, 0, 0);
    step("t3_b", 1, 1, 12, 0, 0);
    chk("t3_full", 32'(fetch_stall_o), 1);
    step("t3_ovf", 1, 0, 16, 0, 0);
    chk("t3_err", 32'(proto_err_o), 1);
    chk("t3_out2", 32'(outstanding_o), 2);
    step("t3_res", 0, 0, 0, 1, 1);
    chk("t3_out1", 32'(outstanding_o), 1);

    // 4: full, push + pop together, then mispredict
    step("t4_fill", 1, 0, 20, 0, 0);
    step("t4_pp", 1, 1, 24, 1, 1);
    chk("t4_out2", 32'(outstanding_o), 2);
    step("t4_mis", 0, 0, 0, 1, 0);
    chk("t4_rpc", redirect_pc_o, 20);
    step("t4_idle", 0, 0, 0, 0, 0);

    // 5: mispredict with a same-cycle issue
    do_reset();
    step("t5_a", 1, 0, 36, 0, 0);
    step("t5_b", 1, 1, 48, 0, 0);
    step("t5_mis", 1, 0, 52, 1, 0);
    chk("t5_rpc", redirect_pc_o, 36);
    chk("t5_out", 32'(outstanding_o), 0);
    chk("t5_err", 32'(proto_err_o), 0);
    step("t5_idle", 0, 0, 0, 0, 0);

    // 6: empty resolve, then reset during FLUSH
    step("t6_emp", 0, 0, 0, 1, 1);
    chk("t6_err", 32'(proto_err_o), 1);
    chk("t6_bpu", 32'(bp_update_o), 0);
    step("t6_iss", 1, 1, 60, 0, 0);
    step("t6_mis", 0, 0, 0, 1, 0);
    chk("t6_inflush", 32'(iq_flush_o), 1);
    reset_i = 1'b1;
    model_reset();
    #1;
    check_all("t6_async");
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    step("t6_run", 1, 0, 64, 0, 0);
    chk("t6_out1", 32'(outstanding_o), 1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 97 == 96) do_reset();
      step("rnd",
           bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)),
           $urandom & 32'hFFFF_FFFC,
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
